// File: rtl/crc_pkg.sv
// Shared definitions for the CRC blocks: frame FSM encoding, mode values
// and commonly used generator polynomials (implicit top bit omitted).
package crc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_CLOSE  = 2'd2
    } state_t;

    localparam logic MODE_GEN = 1'b0;
    localparam logic MODE_CHK = 1'b1;

    localparam logic [7:0]  CRC8_POLY        = 8'h07;
    localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
    localparam logic [31:0] CRC32_POLY       = 32'h04C11DB7;

endpackage

// File: rtl/crc_frame_unit_if.sv
// Beat stream and status bundle of crc_frame_unit; the framing side drives
// the master modport, the CRC engine sits on the slave modport.
interface crc_frame_unit_if #(
    parameter int DATA_W = 8,
    parameter int CRC_W  = 8,
    parameter int CNT_W  = 16
) ();

    logic              start;
    logic              mode;
    logic              data_valid;
    logic [DATA_W-1:0] data_in;
    logic              data_last;

    logic              busy;
    logic [CRC_W-1:0]  crc_out;
    logic              done;
    logic              error;
    logic [CNT_W-1:0]  beat_cnt;
    logic [CNT_W-1:0]  err_cnt;

    modport master (
        output start, mode, data_valid, data_in, data_last,
        input  busy, crc_out, done, error, beat_cnt, err_cnt
    );

    modport slave (
        input  start, mode, data_valid, data_in, data_last,
        output busy, crc_out, done, error, beat_cnt, err_cnt
    );

endinterface

// File: rtl/crc_step.sv
// Combinational CRC update over one DATA_W-bit beat, MSB first, non-reflected.
// The serial LFSR is unrolled so a whole beat is absorbed per cycle.
module crc_step
    import crc_pkg::*;
#(
    parameter int              DATA_W = 8,
    parameter int              CRC_W  = 8,
    parameter logic [CRC_W-1:0] POLY  = CRC_W'(CRC8_POLY)
) (
    input  logic [CRC_W-1:0]  crc_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [CRC_W-1:0]  crc_out
);

    logic [CRC_W-1:0] crc_acc;

    always_comb begin
        // NOTE: blocking assignments are intentional here; each loop pass
        // must see the value produced by the previous serial step.
        crc_acc = crc_in;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (crc_acc[CRC_W-1] ^ data_in[i]) begin
                crc_acc = (crc_acc << 1) ^ POLY;
            end else begin
                crc_acc = crc_acc << 1;
            end
        end
    end

    assign crc_out = crc_acc;

endmodule

// File: rtl/crc_frame_unit.sv
// Framed CRC engine: generates the frame CRC or checks a frame carrying its
// appended CRC, with saturating beat and error statistics.
module crc_frame_unit
    import crc_pkg::*;
#(
    parameter int               DATA_W  = 8,
    parameter int               CRC_W   = 8,
    parameter logic [CRC_W-1:0] POLY    = CRC_W'(CRC8_POLY),
    parameter logic [CRC_W-1:0] INIT    = '0,
    parameter logic [CRC_W-1:0] RESIDUE = '0,
    parameter int               CNT_W   = 16
) (
    input  logic            clk,
    input  logic            rst,
    crc_frame_unit_if.slave bus
);

    state_t           state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [CRC_W-1:0] crc_out_q, crc_out_d;
    logic             mode_q, mode_d;
    logic             error_q, error_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic             accept;
    logic             close_now;
    logic             mode_eff;
    logic             mismatch;
    logic [CRC_W-1:0] crc_base;
    logic [CRC_W-1:0] crc_next;
    logic [CNT_W-1:0] beat_base;

    // A start cycle behaves as the first cycle of a fresh frame, so the beat
    // taken in that cycle is computed from INIT and counted from zero.
    assign accept    = bus.data_valid && (bus.start || (state_q == ST_ACTIVE));
    assign close_now = accept && bus.data_last;
    assign mode_eff  = bus.start ? bus.mode : mode_q;
    assign crc_base  = bus.start ? INIT : crc_q;
    assign beat_base = bus.start ? '0 : beat_cnt_q;
    assign mismatch  = (crc_next != RESIDUE);

    crc_step #(
        .DATA_W (DATA_W),
        .CRC_W  (CRC_W),
        .POLY   (POLY)
    ) u_step (
        .crc_in  (crc_base),
        .data_in (bus.data_in),
        .crc_out (crc_next)
    );

    // State register and datapath registers
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for every flop so all registers
        // update from the same pre-edge values.
        if (rst) begin
            state_q    <= ST_IDLE;
            crc_q      <= INIT;
            crc_out_q  <= '0;
            mode_q     <= MODE_GEN;
            error_q    <= 1'b0;
            beat_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            crc_out_q  <= crc_out_d;
            mode_q     <= mode_d;
            error_q    <= error_d;
            beat_cnt_q <= beat_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Next-state logic; start reopens from any state, aborting an open frame
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned
        // and no latch is inferred.
        state_d = state_q;
        if (bus.start) begin
            state_d = close_now ? ST_CLOSE : ST_ACTIVE;
        end else begin
            unique case (state_q)
                ST_IDLE:   state_d = ST_IDLE;
                ST_ACTIVE: state_d = close_now ? ST_CLOSE : ST_ACTIVE;
                ST_CLOSE:  state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath next values
    always_comb begin
        crc_d      = crc_q;
        crc_out_d  = crc_out_q;
        mode_d     = mode_q;
        error_d    = error_q;
        beat_cnt_d = beat_cnt_q;
        err_cnt_d  = err_cnt_q;

        if (bus.start) begin
            crc_d      = INIT;
            mode_d     = bus.mode;
            error_d    = 1'b0;
            beat_cnt_d = '0;
        end

        if (accept) begin
            crc_d      = crc_next;
            beat_cnt_d = (beat_base == '1) ? beat_base : beat_base + CNT_W'(1);
        end

        // Verdict is registered on the closing edge so it appears with done
        if (close_now) begin
            crc_out_d = crc_next;
            error_d   = (mode_eff == MODE_CHK) && mismatch;
            if ((mode_eff == MODE_CHK) && mismatch && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end
    end

    // Outputs decoded from state and registers
    always_comb begin
        bus.busy     = (state_q == ST_ACTIVE);
        bus.done     = (state_q == ST_CLOSE);
        bus.crc_out  = crc_out_q;
        bus.error    = error_q;
        bus.beat_cnt = beat_cnt_q;
        bus.err_cnt  = err_cnt_q;
    end

endmodule

// File: doc/crc_frame_unit.md
Name: crc_frame_unit

Overview:
Parametrised, beat-parallel CRC engine with runtime generate/check mode, framed by start/data_last. It consumes one DATA_W-bit beat per clk with no backpressure. It sits on the byte-stream datapath between framing logic and the link layer. In generate mode it outputs the frame CRC; in check mode it validates a frame with the CRC appended and keeps beat and error statistics.

Parameters:
DATA_W, 8, beat width in bits; 1..64.
CRC_W, 8, CRC register width; 1..32.
POLY, 8'h07, generator polynomial with implicit top bit omitted; width CRC_W.
INIT, 0, CRC register value loaded at start; width CRC_W.
RESIDUE, 0, expected final register value for a good frame in check mode.
CNT_W, 16, width of the beat and error counters.

Ports:
clk  in  1  clock, all logic rising-edge.
rst  in  1  synchronous reset, active-high.
start  in  1  one-cycle pulse; opens a frame and loads INIT.
mode  in  1  0 = generate, 1 = check; sampled only on start.
data_valid  in  1  beat qualifier.
data_in  in  DATA_W  beat data, MSB processed first.
data_last  in  1  qualifies the final beat of the frame; ignored unless data_valid=1.
busy  out  1  high while the frame is open (ACTIVE).
crc_out  out  CRC_W  final CRC register; held until the next start.
done  out  1  one-cycle pulse at frame close.
error  out  1  check-mode mismatch; valid with done and held until the next start.
beat_cnt  out  CNT_W  beats accepted in the current or last frame; saturates.
err_cnt  out  CNT_W  total check failures since reset; saturates.

Behaviour:
- Reset (rst=1 at edge): state IDLE; crc register=INIT; crc_out=0; busy=0; done=0; error=0; beat_cnt=0; err_cnt=0.
- States: IDLE, ACTIVE, CLOSE.
- IDLE:
  - start moves to ACTIVE: crc register=INIT, latch mode, beat_cnt=0, error=0.
  - data_valid without start is ignored.
- start and data_valid in the same cycle: the beat is accepted as the first beat, computed from INIT, and beat_cnt becomes 1.
- start and data_valid and data_last in the same cycle: a one-beat frame; go directly to CLOSE.
- ACTIVE, each data_valid cycle:
  - crc_next = DATA_W serial steps, MSB first: fb = crc[CRC_W-1]^d; crc = (crc<<1) ^ (fb ? POLY : 0).
  - beat_cnt++ (saturating).
  - With data_last: go to CLOSE and register crc_next into crc_out.
- CLOSE (one cycle): done=1, busy=0, return to IDLE.
  - Check mode: error = (crc_out != RESIDUE); err_cnt++ (saturating) if error.
  - Generate mode: error=0.
- Latency: done is high exactly one cycle after the data_last beat edge. crc_out is valid the same cycle as done and stable until the next start.
- start while ACTIVE: abort the current frame with no done and no err_cnt change; reopen immediately with the same rules as from IDLE.
- start during CLOSE: CLOSE completes (done and error reported), and the new frame opens in the same cycle.
- data_valid=0 cycles inside a frame: register holds; gaps are unlimited.
- Check mode: the sender appends CRC_W bits of CRC, MSB first, as ordinary beats. A good frame then leaves RESIDUE (0 for non-reflected, xor-out-0 CRCs).
- rst mid-frame: immediate return to the reset values above; no done pulse.

Decomposition:
- Shared package crc_pkg: state encoding (IDLE/ACTIVE/CLOSE), MODE_GEN/MODE_CHK constants, named polynomial constants (CRC8_POLY=8'h07, CRC16_CCITT_POLY=16'h1021, CRC32_POLY=32'h04C11DB7).
- Sub-module crc_step: purely combinational crc_next from (crc, data), parametrised by DATA_W/CRC_W/POLY, built as an unrolled loop. It is reused by future CRC blocks.
- The FSM, counters and registers stay in crc_frame_unit.

Test Plan:
1. Defaults, generate, one beat 0xAA with data_last -> done one cycle later; crc_out=0x5F, error=0, beat_cnt=1.
2. Defaults, generate, ASCII "123456789" (9 beats, gaps between beats) -> crc_out=0xF4, beat_cnt=9. Repeat with CRC_W=16, POLY=16'h1021, INIT=0 -> 0x31C3; with INIT=16'hFFFF -> 0x29B1.
3. Defaults, check, beats 0xAA,0x5F -> error=0, err_cnt unchanged. Then beats 0xAA,0xFF -> error=1, crc_out!=0, err_cnt=1.
4. start asserted mid-frame after 3 beats, then new frame 0xAA+last -> no done for the aborted frame; crc_out=0x5F; beat_cnt=1.
5. start, data_valid and data_last all in one cycle with 0xAA -> single-beat frame, done next cycle, crc_out=0x5F. Separately, data_valid in IDLE -> no effect.
6. rst asserted mid-frame -> next cycle busy=0, crc_out=0, counters 0, no done. err_cnt saturates at all-ones when CNT_W=2 after 4 bad frames.
